bc_operand_sequencer: RTL and testbench

Lane-0 consumer of the broadcast buffer's serialized element stream. Accepts a per-instruction configuration (vector length, number of passes), pulls exactly that many elements per pass from the broadcast buffer, and presents them through a one-deep registered stage to the lane's matmul operand path. It also generates the per-pass rewind and the final invalidate that release the buffer.

---
 rtl/bc_operand_sequencer_if.sv | 39 +++
 rtl/bc_operand_sequencer.sv | 106 ++++++++++
 tb/tb_bc_operand_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bc_operand_sequencer_if.sv
// Handshake bundle between the broadcast buffer, the operand sequencer and the lane operand path.
// The slave modport is the sequencer's view; master is the view of the surrounding environment.
interface bc_operand_sequencer_if #(
    parameter int unsigned MaxBlen   = 64,
    parameter int unsigned ElemWidth = 64,
    parameter int unsigned RepWidth  = 8
);
    localparam int unsigned LenWidth = $clog2(MaxBlen + 1);

    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic [LenWidth-1:0]  cfg_len_i;
    logic [RepWidth-1:0]  cfg_reps_i;
    logic                 abort_i;
    logic [ElemWidth-1:0] bc_data_i;
    logic                 bc_data_valid_i;
    logic                 bc_data_ready_o;
    logic                 bc_data_rewind_o;
    logic                 bc_data_invalidate_o;
    logic [ElemWidth-1:0] op_data_o;
    logic                 op_valid_o;
    logic                 op_ready_i;
    logic                 op_last_o;
    logic                 op_final_o;

    modport slave (
        input  cfg_valid_i, cfg_len_i, cfg_reps_i, abort_i, bc_data_i, bc_data_valid_i,
        input  op_ready_i,
        output cfg_ready_o, bc_data_ready_o, bc_data_rewind_o, bc_data_invalidate_o,
        output op_data_o, op_valid_o, op_last_o, op_final_o
    );

    modport master (
        output cfg_valid_i, cfg_len_i, cfg_reps_i, abort_i, bc_data_i, bc_data_valid_i,
        output op_ready_i,
        input  cfg_ready_o, bc_data_ready_o, bc_data_rewind_o, bc_data_invalidate_o,
        input  op_data_o, op_valid_o, op_last_o, op_final_o
    );
endinterface

// File: rtl/bc_operand_sequencer.sv
// Lane-0 broadcast stream consumer: pulls len elements per pass for reps passes through a
// one-deep output register, pulsing rewind between passes and invalidate at job end.
module bc_operand_sequencer #(
    parameter int unsigned MaxBlen   = 64,
    parameter int unsigned ElemWidth = 64,
    parameter int unsigned RepWidth  = 8
) (
    input logic clk_i,
    input logic rst_i,
    bc_operand_sequencer_if.slave bus
);
    localparam int unsigned LenWidth = $clog2(MaxBlen + 1);

    typedef enum logic [2:0] {StIdle, StStream, StRewind, StDrain, StInval} state_e;

    state_e               state_q;
    logic [LenWidth-1:0]  len_q, elem_cnt_q;
    logic [RepWidth-1:0]  reps_q, pass_cnt_q;
    logic [ElemWidth-1:0] op_data_q;
    logic                 op_valid_q, op_last_q, op_final_q;
    logic                 bc_ready, bc_hs, op_hs, elem_last, pass_last;

    // len_q and reps_q are non-zero whenever StStream is reachable, so the decrements never wrap.
    always_comb begin
        op_hs     = op_valid_q && bus.op_ready_i;
        bc_ready  = !rst_i && (state_q == StStream) && (!op_valid_q || bus.op_ready_i);
        bc_hs     = bc_ready && bus.bc_data_valid_i;
        elem_last = (elem_cnt_q == len_q - LenWidth'(1));
        pass_last = (pass_cnt_q == reps_q - RepWidth'(1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            reps_q     <= '0;
            elem_cnt_q <= '0;
            pass_cnt_q <= '0;
            op_data_q  <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            op_final_q <= 1'b0;
        end else if (bus.abort_i && (state_q != StIdle)) begin
            // Any element accepted upstream this cycle is deliberately dropped.
            state_q    <= StInval;
            elem_cnt_q <= '0;
            pass_cnt_q <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            op_final_q <= 1'b0;
        end else begin
            if (bc_hs) begin
                op_data_q  <= bus.bc_data_i;
                op_valid_q <= 1'b1;
                op_last_q  <= elem_last;
                op_final_q <= elem_last && pass_last;
            end else if (op_hs) begin
                op_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.cfg_valid_i) begin
                        len_q      <= bus.cfg_len_i;
                        reps_q     <= bus.cfg_reps_i;
                        elem_cnt_q <= '0;
                        pass_cnt_q <= '0;
                        state_q    <= (bus.cfg_len_i == '0 || bus.cfg_reps_i == '0) ?
                                      StInval : StStream;
                    end
                end
                StStream: begin
                    if (bc_hs) begin
                        if (!elem_last) begin
                            elem_cnt_q <= elem_cnt_q + LenWidth'(1);
                        end else if (pass_last) begin
                            elem_cnt_q <= '0;
                            state_q    <= StDrain;
                        end else begin
                            elem_cnt_q <= '0;
                            pass_cnt_q <= pass_cnt_q + RepWidth'(1);
                            state_q    <= StRewind;
                        end
                    end
                end
                StRewind: state_q <= StStream;
                StDrain: begin
                    if (!op_valid_q || op_hs) begin
                        state_q <= StInval;
                    end
                end
                StInval: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cfg_ready_o          = !rst_i && (state_q == StIdle);
    assign bus.bc_data_ready_o      = bc_ready;
    assign bus.bc_data_rewind_o     = !rst_i && (state_q == StRewind);
    assign bus.bc_data_invalidate_o = !rst_i && (state_q == StInval);
    assign bus.op_data_o            = op_data_q;
    assign bus.op_valid_o           = op_valid_q;
    assign bus.op_last_o            = op_last_q;
    assign bus.op_final_o           = op_final_q;
endmodule

// File: tb/tb_bc_operand_sequencer.sv
// Randomized self-checking bench: an upstream buffer model replays elements per pass and a
// pass/element reference list gives the operand stream the sequencer must produce.
module tb_bc_operand_sequencer;
    localparam int unsigned MaxBlen = 64;
    localparam int unsigned LW      = $clog2(MaxBlen + 1);

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        f;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bc_operand_sequencer_if #(.MaxBlen(MaxBlen), .ElemWidth(64), .RepWidth(8)) bus ();

    bc_operand_sequencer #(.MaxBlen(MaxBlen), .ElemWidth(64), .RepWidth(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] up_data [0:MaxBlen-1];
    int   up_idx;
    out_t got_q[$];
    out_t exp_q[$];
    int   n_rew, n_inv, n_bc, n_opv, stall_err, bp_err, rst_err;
    int   first_out, last_out, last_bc_cyc, first_bcr_cyc, inv_cyc, idle_cyc, abort_cyc;
    logic valid_after_abort;
    bit   timed_out;

    // Reference stream: every pass replays the same len elements; last/final from position only.
    task automatic build_exp(input int len, input int reps);
        exp_q.delete();
        for (int p = 0; p < reps; p++)
            for (int i = 0; i < len; i++)
                exp_q.push_back('{d: up_data[i], l: (i == len - 1),
                                  f: (i == len - 1) && (p == reps - 1)});
    endtask

    task automatic clear_inputs();
        bus.cfg_valid_i     = 1'b0;
        bus.cfg_len_i       = '0;
        bus.cfg_reps_i      = '0;
        bus.abort_i         = 1'b0;
        bus.bc_data_i       = '0;
        bus.bc_data_valid_i = 1'b0;
        bus.op_ready_i      = 1'b0;
    endtask

    // Drives one job and records observations; rmode 0=ready high, 1=1,0,0,1 pattern, 2=random.
    task automatic run_job(input int len, input int reps, input int rmode, input bit vrand,
                           input int abort_at, input int rst_at);
        int   rst_left = 0;
        bit   ab_done = 0, rs_done = 0, ab_now, pv = 0, pr = 0;
        out_t po = '0, cur;
        got_q.delete();
        n_rew = 0; n_inv = 0; n_bc = 0; n_opv = 0; stall_err = 0; bp_err = 0; rst_err = 0;
        first_out = -1; last_out = -1; last_bc_cyc = -1; first_bcr_cyc = -1;
        inv_cyc = -1; idle_cyc = -1; abort_cyc = -1; valid_after_abort = 1'bx;
        up_idx = 0; timed_out = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            ab_now = (abort_at > 0) && !ab_done && (got_q.size() == abort_at);
            if ((rst_at > 0) && !rs_done && (got_q.size() == rst_at)) begin
                rst_left = 3;
                rs_done  = 1;
            end
            rst                 = (rst_left > 0);
            bus.cfg_valid_i     = (cyc == 0);
            bus.cfg_len_i       = LW'(len);
            bus.cfg_reps_i      = 8'(reps);
            bus.abort_i         = ab_now;
            case (rmode)
                0:       bus.op_ready_i = 1'b1;
                1:       bus.op_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.op_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (ab_now || rst) bus.op_ready_i = 1'b0;
            bus.bc_data_valid_i = (up_idx < len) && (!vrand || $urandom_range(0, 3) != 0);
            bus.bc_data_i       = (up_idx < len) ? up_data[up_idx] : 64'h0;
            #1;
            if (ab_done && cyc == abort_cyc + 1) valid_after_abort = bus.op_valid_o;
            if (ab_now) begin
                abort_cyc = cyc;
                ab_done   = 1;
            end
            if (rst && rst_left < 3 &&
                {bus.cfg_ready_o, bus.bc_data_ready_o, bus.bc_data_rewind_o,
                 bus.bc_data_invalidate_o, bus.op_valid_o, bus.op_last_o, bus.op_final_o,
                 bus.op_data_o} !== '0)
                rst_err++;
            cur = '{d: bus.op_data_o, l: bus.op_last_o, f: bus.op_final_o};
            if (pv && !pr && (!bus.op_valid_o || cur !== po)) stall_err++;
            if (bus.op_valid_o && !bus.op_ready_i && bus.bc_data_ready_o) bp_err++;
            if (bus.bc_data_ready_o && first_bcr_cyc < 0) first_bcr_cyc = cyc;
            if (bus.bc_data_ready_o && bus.bc_data_valid_i) begin
                n_bc++;
                up_idx++;
                last_bc_cyc = cyc;
            end
            if (bus.bc_data_rewind_o) begin
                n_rew++;
                up_idx = 0;
            end
            if (bus.bc_data_invalidate_o) begin
                n_inv++;
                inv_cyc = cyc;
            end
            if (bus.op_valid_o) n_opv++;
            if (bus.op_valid_o && bus.op_ready_i) begin
                got_q.push_back(cur);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            pv = bus.op_valid_o && !ab_now && !rst;
            pr = bus.op_ready_i;
            po = cur;
            if (rst_left > 0) rst_left--;
            if (cyc > 0 && bus.cfg_ready_o) begin
                idle_cyc = cyc;
                break;
            end
        end
        if (idle_cyc < 0) timed_out = 1;
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.cfg_ready_o, bus.bc_data_ready_o, bus.bc_data_rewind_o, bus.bc_data_invalidate_o,
             bus.op_valid_o, bus.op_last_o, bus.op_final_o, bus.op_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cfg_ready=%b op_valid=%b inval=%b, want all 0",
                     bus.cfg_ready_o, bus.op_valid_o, bus.bc_data_invalidate_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle: cfg_ready=%b want 1", bus.cfg_ready_o);
        end
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        #1;
        checks++;
        if ({bus.cfg_ready_o, bus.bc_data_invalidate_o} !== 2'b10) begin
            errors++;
            $display("FAIL idle_abort_ignored: cfg_ready=%b inval=%b want 1 0",
                     bus.cfg_ready_o, bus.bc_data_invalidate_o);
        end
    endtask

    task automatic test_single_pass();
        for (int i = 0; i < 4; i++) up_data[i] = 64'(i);
        build_exp(4, 1);
        run_job(4, 1, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != 4) begin
            errors++;
            $display("FAIL single_count: got %0d outputs timeout=%0d want 4", got_q.size(), timed_out);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_elem%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (first_bcr_cyc != 1 || last_out - first_out != 3) begin
            errors++;
            $display("FAIL single_timing: ready_cyc=%0d span=%0d want 1 3",
                     first_bcr_cyc, last_out - first_out);
        end
        checks++;
        if (n_inv != 1 || inv_cyc != last_bc_cyc + 2 || idle_cyc != last_bc_cyc + 3) begin
            errors++;
            $display("FAIL single_final: inv=%0d inv_cyc=%0d idle_cyc=%0d want 1 %0d %0d",
                     n_inv, inv_cyc, idle_cyc, last_bc_cyc + 2, last_bc_cyc + 3);
        end
    endtask

    task automatic test_multi_pass();
        for (int i = 0; i < 3; i++) up_data[i] = 64'(10 + i);
        build_exp(3, 3);
        run_job(3, 3, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != 9 || n_rew != 2 || n_inv != 1) begin
            errors++;
            $display("FAIL multi_counts: outs=%0d rew=%0d inv=%0d want 9 2 1",
                     got_q.size(), n_rew, n_inv);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL multi_elem%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        // 9 outputs plus one bubble per pass boundary.
        checks++;
        if (last_out - first_out != 10) begin
            errors++;
            $display("FAIL multi_bubbles: span=%0d want 10", last_out - first_out);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) up_data[i] = {$urandom, $urandom};
        build_exp(8, 1);
        run_job(8, 1, 1, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != 8 || n_inv != 1) begin
            errors++;
            $display("FAIL bp_count: outs=%0d inv=%0d want 8 1", got_q.size(), n_inv);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_elem%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_err != 0 || bp_err != 0) begin
            errors++;
            $display("FAIL bp_stall: unstable=%0d ready_leaks=%0d want 0 0", stall_err, bp_err);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 4; j++) begin
            int len  = $urandom_range(1, 12);
            int reps = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) up_data[i] = {$urandom, $urandom};
            build_exp(len, reps);
            run_job(len, reps, 2, 1, 0, 0);
            checks++;
            if (timed_out || got_q.size() != len * reps || n_rew != reps - 1 || n_inv != 1) begin
                errors++;
                $display("FAIL rand%0d_counts: outs=%0d rew=%0d inv=%0d want %0d %0d 1",
                         j, got_q.size(), n_rew, n_inv, len * reps, reps - 1);
            end
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_elem%0d: got %h want %h", j, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (stall_err != 0 || bp_err != 0) begin
                errors++;
                $display("FAIL rand%0d_stall: unstable=%0d leaks=%0d want 0 0", j, stall_err, bp_err);
            end
        end
    endtask

    task automatic test_empty();
        int lens[2] = '{0, 5};
        int repv[2] = '{5, 0};
        for (int j = 0; j < 2; j++) begin
            run_job(lens[j], repv[j], 0, 0, 0, 0);
            checks++;
            if (n_bc != 0 || n_opv != 0 || n_inv != 1 || inv_cyc != 1 || idle_cyc != 2) begin
                errors++;
                $display("FAIL empty%0d: bc=%0d opv=%0d inv=%0d@%0d idle@%0d want 0 0 1@1 idle@2",
                         j, n_bc, n_opv, n_inv, inv_cyc, idle_cyc);
            end
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) up_data[i] = {$urandom, $urandom};
        build_exp(16, 2);
        run_job(16, 2, 0, 0, 5, 0);
        checks++;
        if (timed_out || got_q.size() != 5 || valid_after_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: outs=%0d valid_next=%b want 5 0", got_q.size(), valid_after_abort);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_elem%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (n_inv != 1 || inv_cyc != abort_cyc + 1 || idle_cyc != abort_cyc + 2) begin
            errors++;
            $display("FAIL abort_inval: inv=%0d@%0d idle@%0d want 1@%0d idle@%0d",
                     n_inv, inv_cyc, idle_cyc, abort_cyc + 1, abort_cyc + 2);
        end
        up_data[0] = 64'hA5A5_0000_0000_0001;
        up_data[1] = 64'h5A5A_0000_0000_0002;
        build_exp(2, 1);
        run_job(2, 1, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != 2 || n_inv != 1) begin
            errors++;
            $display("FAIL post_abort_count: outs=%0d inv=%0d want 2 1", got_q.size(), n_inv);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL post_abort_elem%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stop = 99 * MaxBlen + 32;
        for (int i = 0; i < MaxBlen; i++) up_data[i] = {$urandom, $urandom};
        build_exp(MaxBlen, 255);
        run_job(MaxBlen, 255, 0, 0, 0, stop);
        checks++;
        if (timed_out || got_q.size() != stop || n_rew != 99) begin
            errors++;
            $display("FAIL rstmid_counts: outs=%0d rew=%0d want %0d 99", got_q.size(), n_rew, stop);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_elem%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rst_err != 0 || n_inv != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: nonzero_cycles=%0d inval=%0d want 0 0", rst_err, n_inv);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_backpressure();
        test_random();
        test_empty();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
